// File: rtl/async_queue_reader_if.sv
// Pop-side bundle of the async queue plus the downstream valid/ready stream.
interface async_queue_reader_if #(
  parameter int W = 32
);
  logic         q_empty_r;
  logic         q_pop;
  logic [W-1:0] q_pop_data;
  logic         q_pop_data_vld_r;
  logic         out_vld;
  logic [W-1:0] out_data;
  logic         out_rdy;

  // Reader side: pops the queue, drives the stream.
  modport master (
    input  q_empty_r, q_pop_data, q_pop_data_vld_r, out_rdy,
    output q_pop, out_vld, out_data
  );

  // Environment side: the queue and the downstream consumer.
  modport slave (
    output q_empty_r, q_pop_data, q_pop_data_vld_r, out_rdy,
    input  q_pop, out_vld, out_data
  );
endinterface

// File: rtl/async_queue_reader.sv
// Read-side controller for the async queue: credit-based popping into a small
// ring buffer, valid/ready output stream, flush/drain sequence, stray-data error.
module async_queue_reader #(
  parameter int W     = 32,
  parameter int D     = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 flush,
  async_queue_reader_if.master qif,
  output logic                 flush_done,
  output logic                 busy,
  output logic [CNT_W-1:0]     pop_cnt_r,
  output logic                 proto_err_r
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int OW = $clog2(D + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state;
  logic [W-1:0]  mem [D];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [OW-1:0] occ, occ_nxt;
  logic [OW:0]   credit_use;
  logic          inflight_r;
  logic          out_vld_r;
  logic          wr_en, rd_en, flush_now;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign busy         = (state == FLUSH);
  assign qif.out_vld  = out_vld_r;
  assign qif.out_data = mem[rd_ptr];

  // Pop decision and buffer write/read enables.
  // Credit counts the word already in flight so the buffer can never overflow.
  always_comb begin
    credit_use = {1'b0, occ} + (OW+1)'(inflight_r);
    flush_now  = (state == RUN) & flush;
    if (state == FLUSH) begin
      qif.q_pop = ~qif.q_empty_r;
    end else begin
      qif.q_pop = en & ~qif.q_empty_r & (credit_use < (OW+1)'(D));
    end
    wr_en   = (state == RUN) & ~flush & qif.q_pop_data_vld_r & inflight_r;
    rd_en   = (state == RUN) & out_vld_r & qif.out_rdy;
    occ_nxt = occ + OW'(wr_en) - OW'(rd_en);
  end

  // FSM: RUN <-> FLUSH, with a one-cycle flush_done pulse on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        RUN: begin
          if (flush) state <= FLUSH;
        end
        FLUSH: begin
          if (qif.q_empty_r && !inflight_r) begin
            state      <= RUN;
            flush_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Ring buffer pointers, occupancy and registered out_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      out_vld_r <= 1'b0;
    end else if (flush_now || state == FLUSH) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      out_vld_r <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      occ       <= occ_nxt;
      out_vld_r <= (occ_nxt != '0);
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= qif.q_pop_data;
  end

  // In-flight tracking, pop counter and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r  <= 1'b0;
      pop_cnt_r   <= '0;
      proto_err_r <= 1'b0;
    end else begin
      inflight_r <= qif.q_pop;
      pop_cnt_r  <= pop_cnt_r + CNT_W'(qif.q_pop);
      if (qif.q_pop_data_vld_r && !inflight_r) proto_err_r <= 1'b1;
    end
  end
endmodule

// File: doc/async_queue_reader.md
# async_queue_reader

Single-clock read-side controller for the async queue's pop interface, operating in the queue's read-clock domain. It issues pops whenever the queue is non-empty and local buffer credit is available, and it absorbs the queue's one-cycle pop-data latency. Popped words are presented downstream on a valid/ready stream. It also provides a flush sequence that drains and discards the queue contents, and it detects protocol errors.

## Interface
- W, 32, data word width.
- D, 4, output buffer depth in entries; minimum 2; D >= 3 is required for one word per cycle.
- CNT_W, 16, width of the popped-word counter.

- clk  in  1  clock; the queue's read clock.
- rst_n  in  1  reset; asynchronous assert, active-low, synchronously deasserted upstream.
- en  in  1  enables normal popping; it has no effect on a flush in progress.
- q_empty_r  in  1  queue empty flag (registered in the queue).
- q_pop  out  1  pop strobe to the queue; combinational.
- q_pop_data  in  W  queue read data, valid when q_pop_data_vld_r = 1.
- q_pop_data_vld_r  in  1  high exactly one cycle after each q_pop.
- out_vld  out  1  downstream valid; registered.
- out_data  out  W  downstream data (buffer head).
- out_rdy  in  1  downstream ready.
- flush  in  1  single-cycle request to drain and discard the queue.
- flush_done  out  1  single-cycle pulse when a flush completes; registered.
- busy  out  1  high while state != RUN.
- pop_cnt_r  out  CNT_W  count of pops issued; wraps modulo 2^CNT_W.
- proto_err_r  out  1  sticky error flag.

## Operation
- Internal state:
  - D-entry ring buffer with rd/wr pointers and occupancy occ (0..D).
  - inflight_r, a flop equal to last cycle's q_pop.
  - FSM with states RUN, FLUSH.
- RUN:
  - q_pop = en & ~q_empty_r & (occ + inflight_r < D).
  - A cycle with q_pop_data_vld_r = 1 writes q_pop_data into the buffer.
  - out_vld = (occ != 0); out_data = buffer head.
  - out_vld & out_rdy pops the head.
  - A write and a read in the same cycle leave occ unchanged.
- The buffer never overflows in legal operation; the credit rule guarantees this.
- flush in RUN:
  - Next state FLUSH.
  - The buffer is cleared: occ = 0, pointers = 0.
  - A word arriving in the transition cycle is discarded.
- FLUSH:
  - q_pop = ~q_empty_r, regardless of en and credit.
  - All arriving data is discarded; out_vld = 0.
  - Exit when q_empty_r = 1 and inflight_r = 0: flush_done pulses for one cycle and the next state is RUN.
  - flush is ignored while in FLUSH.
- pop_cnt_r increments on every q_pop, in both RUN and FLUSH.
- proto_err_r is set when q_pop_data_vld_r = 1 and inflight_r = 0. It is cleared only by reset. The stray word is dropped.
- Reset values:
  - FSM = RUN; occ = 0; pointers = 0; inflight_r = 0.
  - out_vld = 0, flush_done = 0, busy = 0, pop_cnt_r = 0, proto_err_r = 0.
  - q_pop = 0, because q_empty_r = 1 from the queue under reset.
  - out_data is don't-care while out_vld = 0.

## Timing
- Latency:
  - Pop issued in cycle T.
  - q_pop_data_vld_r in cycle T+1.
  - out_vld in cycle T+2 (first word after idle).
- Throughput: one word per cycle with out_rdy held high and D >= 3. With D = 2, at most one word every 2 cycles.
- Downstream handshake:
  - out_vld, once high, holds until accepted.
  - out_data is stable while out_vld & ~out_rdy.
- q_pop depends combinationally on q_empty_r, en and registered state only. It has no path from out_rdy.
- Reset asserted mid-operation:
  - All state clears immediately.
  - Any data in the buffer or in flight is lost.
  - A q_pop_data_vld_r arriving after reset release with inflight_r = 0 sets proto_err_r. The bench must quiesce the queue across reset.
- Flush latency: at least 2 cycles from the flush pulse to flush_done, even when the queue is empty (one cycle for the FSM transition, one for the exit check).

## Test plan
- Streaming:
  - Stimulus: reset, then queue holds 8 words 0x10..0x17, en = 1, out_rdy = 1, D = 4.
  - Required: q_pop high for 8 consecutive cycles; out_vld high for 8 consecutive cycles starting 2 cycles after the first q_pop; data 0x10..0x17 in order; pop_cnt_r = 8.
- Backpressure:
  - Stimulus: out_rdy = 0 with 10 words queued.
  - Required: exactly 4 pops issued; occ = 4; q_pop low thereafter; out_data holds 0x10.
  - Stimulus: raise out_rdy.
  - Required: all 10 words delivered in order; no loss or duplication.
- Empty boundary:
  - Stimulus: queue holds 1 word.
  - Required: exactly one q_pop; q_pop stays low while q_empty_r = 1; out_vld for one transfer.
- Flush:
  - Stimulus: 5 words queued, 2 words buffered, out_rdy = 0, then a flush pulse.
  - Required: out_vld drops the next cycle; 5 discarding pops; flush_done pulses once, after q_empty_r = 1 and inflight_r = 0; busy high throughout; returns to RUN with out_vld = 0; pop_cnt_r includes the discarded pops.
- Protocol error:
  - Stimulus: drive q_pop_data_vld_r = 1 with no preceding q_pop.
  - Required: proto_err_r = 1 from the next cycle and stays set; buffer unchanged.
- Reset mid-stream:
  - Stimulus: assert rst_n = 0 asynchronously while out_vld = 1.
  - Required: out_vld, pop_cnt_r, busy and flush_done are all 0 before the next clk edge.
